// File: rtl/calc_pkg.sv
// Shared key codes, encodings and sign/magnitude helpers for the keypad calculator.
package calc_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAG_W  = 31;

  // Largest magnitude that can still take another digit without leaving 31 bits
  localparam logic [MAG_W-1:0] MAG_LIMIT = 31'd214748364;

  localparam logic [CODE_W-1:0] KEY_NONE = 5'd0;
  localparam logic [CODE_W-1:0] KEY_D0   = 5'd1;
  localparam logic [CODE_W-1:0] KEY_D9   = 5'd10;
  localparam logic [CODE_W-1:0] KEY_ADD  = 5'd11;
  localparam logic [CODE_W-1:0] KEY_SUB  = 5'd12;
  localparam logic [CODE_W-1:0] KEY_AND  = 5'd13;
  localparam logic [CODE_W-1:0] KEY_OR   = 5'd14;
  localparam logic [CODE_W-1:0] KEY_SIGN = 5'd15;
  localparam logic [CODE_W-1:0] KEY_EQ   = 5'd16;
  localparam logic [CODE_W-1:0] KEY_CLR  = 5'd17;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    WAIT_RES = 2'd2,
    SHOW_RES = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [CODE_W-1:0] key);
    return (key >= KEY_D0) && (key <= KEY_D9);
  endfunction

  function automatic logic is_op(input logic [CODE_W-1:0] key);
    return (key >= KEY_ADD) && (key <= KEY_OR);
  endfunction

  function automatic logic [DATA_W-1:0] to_twos(input logic sgn, input logic [MAG_W-1:0] mag);
    logic [DATA_W-1:0] ext;
    ext = {1'b0, mag};
    return sgn ? -ext : ext;
  endfunction

  // -2^31 has no 31-bit magnitude and folds to zero
  function automatic logic [MAG_W-1:0] abs_mag(input logic [DATA_W-1:0] value);
    logic [DATA_W-1:0] neg;
    neg = -value;
    return value[DATA_W-1] ? MAG_W'(neg) : MAG_W'(value);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Turns a held keypad code into exactly one key event per click.
module key_debounce
  import calc_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code,
  output logic              key_valid_c,
  output logic [CODE_W-1:0] key_c
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] last_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic              armed;

  // Count consecutive cycles of an unchanged nonzero code, saturating at the target
  always_comb begin
    cnt_n = '0;
    if ((code_q != '0) && (code_q == last_q)) begin
      cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end
  end

  assign key_valid_c = armed && (code_q != '0) && (cnt == CNT_MAX);
  assign key_c       = code_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= '0;
      last_q <= '0;
      cnt    <= '0;
      armed  <= 1'b1;
    end else begin
      code_q <= code;
      last_q <= code_q;
      cnt    <= cnt_n;
      // Disarm on fire; only a released keypad re-arms
      if (key_valid_c) begin
        armed <= 1'b0;
      end else if (code_q == '0) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_keypad_entry.sv
// Operand-entry sequencer: debounced keys build two signed operands and drive the calculator handshake.
module calc_keypad_entry
  import calc_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code,
  input  logic              done,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] num_a,
  output logic [DATA_W-1:0] num_b,
  output logic [1:0]        op,
  output logic              go,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] disp,
  output logic [1:0]        state
);

  logic              key_valid_c;
  logic [CODE_W-1:0] key_c;

  key_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .key_valid_c(key_valid_c),
    .key_c      (key_c)
  );

  state_e            cur_st, nxt_st;
  logic [MAG_W-1:0]  mag_a, mag_a_n, mag_b, mag_b_n;
  logic              sgn_a, sgn_a_n, sgn_b, sgn_b_n;
  op_e               op_q, op_n;
  logic              err_n, go_n;
  logic [DATA_W-1:0] res_q, res_n;
  logic [DATA_W-1:0] disp_n;

  logic [MAG_W-1:0]  cur_mag, digit_mag, mag_shift;
  logic [3:0]        digit;
  logic              digit_ok;
  logic              key_digit, key_op, key_sign, key_eq, key_clr;

  // Decode the key event and prepare the decimal shift of the active operand
  always_comb begin
    key_digit = key_valid_c && is_digit(key_c);
    key_op    = key_valid_c && is_op(key_c);
    key_sign  = key_valid_c && (key_c == KEY_SIGN);
    key_eq    = key_valid_c && (key_c == KEY_EQ);
    key_clr   = key_valid_c && (key_c == KEY_CLR);
    digit     = 4'(key_c - KEY_D0);
    digit_mag = MAG_W'(digit);
    cur_mag   = (cur_st == ENTER_B) ? mag_b : mag_a;
    mag_shift = (cur_mag << 3) + (cur_mag << 1) + digit_mag;
    digit_ok  = !((cur_mag > MAG_LIMIT) || ((cur_mag == MAG_LIMIT) && (digit > 4'd7)));
  end

  always_comb begin
    nxt_st  = cur_st;
    mag_a_n = mag_a;
    mag_b_n = mag_b;
    sgn_a_n = sgn_a;
    sgn_b_n = sgn_b;
    op_n    = op_q;
    err_n   = err;
    go_n    = 1'b0;
    res_n   = res_q;
    disp_n  = '0;

    unique case (cur_st)
      ENTER_A: begin
        if (key_digit) begin
          if (digit_ok) mag_a_n = mag_shift;
          else          err_n   = 1'b1;
        end else if (key_sign) begin
          sgn_a_n = ~sgn_a;
        end else if (key_op) begin
          op_n    = op_e'(2'(key_c - KEY_ADD));
          mag_b_n = '0;
          sgn_b_n = 1'b0;
          nxt_st  = ENTER_B;
        end
      end
      ENTER_B: begin
        if (key_digit) begin
          if (digit_ok) mag_b_n = mag_shift;
          else          err_n   = 1'b1;
        end else if (key_sign) begin
          sgn_b_n = ~sgn_b;
        end else if (key_op) begin
          op_n = op_e'(2'(key_c - KEY_ADD));
        end else if (key_eq) begin
          go_n   = 1'b1;
          nxt_st = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (done) begin
          res_n  = result;
          nxt_st = SHOW_RES;
        end
      end
      SHOW_RES: begin
        if (key_digit) begin
          mag_a_n = digit_mag;
          sgn_a_n = 1'b0;
          mag_b_n = '0;
          sgn_b_n = 1'b0;
          nxt_st  = ENTER_A;
        end else if (key_op) begin
          // Chain the previous result into operand A
          mag_a_n = abs_mag(res_q);
          sgn_a_n = res_q[DATA_W-1];
          op_n    = op_e'(2'(key_c - KEY_ADD));
          mag_b_n = '0;
          sgn_b_n = 1'b0;
          nxt_st  = ENTER_B;
        end else if (key_sign) begin
          res_n = -res_q;
        end else if (key_eq) begin
          go_n   = 1'b1;
          nxt_st = WAIT_RES;
        end
      end
      default: nxt_st = ENTER_A;
    endcase

    // Clear overrides everything, including a coincident done
    if (key_clr) begin
      nxt_st  = ENTER_A;
      mag_a_n = '0;
      mag_b_n = '0;
      sgn_a_n = 1'b0;
      sgn_b_n = 1'b0;
      op_n    = OP_ADD;
      err_n   = 1'b0;
      go_n    = 1'b0;
      res_n   = res_q;
    end

    unique case (nxt_st)
      ENTER_B:  disp_n = to_twos(sgn_b_n, mag_b_n);
      SHOW_RES: disp_n = res_n;
      default:  disp_n = to_twos(sgn_a_n, mag_a_n);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st <= ENTER_A;
      mag_a  <= '0;
      mag_b  <= '0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      op_q   <= OP_ADD;
      err    <= 1'b0;
      go     <= 1'b0;
      busy   <= 1'b0;
      res_q  <= '0;
      num_a  <= '0;
      num_b  <= '0;
      disp   <= '0;
    end else begin
      cur_st <= nxt_st;
      mag_a  <= mag_a_n;
      mag_b  <= mag_b_n;
      sgn_a  <= sgn_a_n;
      sgn_b  <= sgn_b_n;
      op_q   <= op_n;
      err    <= err_n;
      go     <= go_n;
      busy   <= (nxt_st == WAIT_RES);
      res_q  <= res_n;
      num_a  <= to_twos(sgn_a_n, mag_a_n);
      num_b  <= to_twos(sgn_b_n, mag_b_n);
      disp   <= disp_n;
    end
  end

  assign op    = op_q;
  assign state = cur_st;

endmodule
